bus_line_filler: RTL
====================

BUS_LINE_FILLER -- requirements
Module: bus_line_filler

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, beats per line transfer (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, per-beat wait limit (only used under BUS_TIMEOUT_EN).
REQ-003 SHALL have ports, one per entry:
- clk  in  1  sole clock, rising edge.
- Nrst  in  1  asynchronous active-low reset.
- req_valid  in  1  line request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  32  start byte address; bits [1:0] ignored.
- req_wr  in  1  1 = write line, 0 = read line.
- wr_data  in  32  head of write-data source.
- wr_pop  out  1  wr_data consumed this cycle.
- rd_data  out  32  captured read beat.
- rd_valid  out  1  rd_data valid, one-cycle pulse per beat.
- done  out  1  one-cycle pulse, line transfer ended.
- err  out  1  with done: transfer aborted.
- bus_addr  out  32  bus address to slave.
- bus_wdata  out  32  bus write data.
- bus_rd  out  1  bus read strobe.
- bus_wr  out  1  bus write strobe.
- bus_rdata  in  32  bus read data (slave drives 0 when not selected).
- bus_ready  in  1  slave beat completion, combinational from slave.

Function
REQ-004 SHALL implement states IDLE, XFER, DONE; IDLE after reset.
REQ-005 SHALL assert req_ready only in IDLE; req_valid && req_ready at an edge latches req_addr, req_wr and moves to XFER.
REQ-006 SHALL assert bus_rd (read) or bus_wr (write) in every XFER cycle, never both; both low in IDLE and DONE.
REQ-007 SHALL hold bus_addr, bus_rd, bus_wr stable within a beat until bus_ready is sampled high.
REQ-008 SHALL complete a beat at each XFER edge with bus_ready high; a high bus_ready outside XFER SHALL be ignored.
REQ-009 SHALL order beats critical-word-first: word index starts at req_addr[k+1:2] (k = log2 LINE_WORDS), increments by 1 per beat, wraps modulo LINE_WORDS; upper bits req_addr[31:k+2] fixed; bus_addr[1:0] = 0.
REQ-010 SHALL issue exactly LINE_WORDS beats, then enter DONE for exactly one cycle, then IDLE.
REQ-011 Read: SHALL register bus_rdata into rd_data at the completing edge and pulse rd_valid for the following cycle; rd_data holds last value otherwise.
REQ-012 Write: bus_wdata SHALL equal wr_data combinationally; wr_pop = XFER && bus_wr && bus_ready; bus_wdata SHALL be 0 when bus_wr low.
REQ-013 SHALL pulse done in the DONE cycle; err low in that cycle unless REQ-018 applies.
REQ-014 SHALL accept no new request until back in IDLE (minimum request-to-request spacing LINE_WORDS+2 cycles with zero-wait slave).
REQ-015 Latency: first strobe one cycle after acceptance; with bus_ready held high, beat n completes at acceptance edge + n.

Reset
REQ-016 Nrst low SHALL immediately force IDLE, beat count 0, latched address 0, and all outputs low/zero except req_ready, which SHALL be 1 after release; applies mid-transfer, no done pulse issued for the aborted line.
REQ-017 SHALL not depend on any register initial value other than reset.

Configuration
REQ-018 With BUS_TIMEOUT_EN defined: a per-beat counter clears on each beat start; if TIMEOUT_CYCLES consecutive XFER cycles pass without bus_ready, SHALL abandon remaining beats, go to DONE, pulse done with err=1.
REQ-019 Without BUS_TIMEOUT_EN: no counter, waits indefinitely per beat, err tied 0.

Verification
REQ-020 Read, req_addr=0x80000000, slave ready after 2 wait cycles each beat, rdata=addr -> 8 rd_valid pulses, data 0x80000000..0x8000001C in order, one done, err=0.
REQ-021 Read, req_addr=0x80000014, zero-wait -> bus_addr sequence 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (base 0x80000000), done at accept+9.
REQ-022 Write, wr_data source 0xA0..0xA7, random waits -> 8 wr_pop pulses, each bus_wdata matching popped word, bus_rd never high.
REQ-023 Nrst pulled low after beat 3 of read -> bus_rd low same cycle, no done, next request after release starts at its own address.
REQ-024 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> done and err high together 17 cycles after acceptance, then req_ready=1.
REQ-025 bus_ready held high while IDLE and req_valid low -> no rd_valid, wr_pop, or done.

Source files
------------

// File: rtl/bus_line_filler.sv
// Cache-line bus filler: issues LINE_WORDS critical-word-first beats per request.
// Optional per-beat timeout abort is enabled with `define BUS_TIMEOUT_EN.
module bus_line_filler #(
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);
  localparam int K = $clog2(LINE_WORDS);
  localparam logic [K-1:0] LAST = K'(LINE_WORDS - 1);

  if (LINE_WORDS < 2 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_lw
    $error("LINE_WORDS must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic [29-K:0] base_q;
  logic [K-1:0]  idx_q, beat_q;
  logic          wr_q;
  logic          in_xfer, abort;
  logic          unused_ok;

  assign unused_ok = &{1'b0, req_addr[1:0]};
  assign in_xfer   = (state == XFER);

  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign bus_rd    = in_xfer && !wr_q;
  assign bus_wr    = in_xfer && wr_q;
  assign bus_addr  = in_xfer ? {base_q, idx_q, 2'b00} : '0;
  assign bus_wdata = bus_wr ? wr_data : '0;
  assign wr_pop    = bus_wr && bus_ready;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic          err_q;

  // Counts consecutive stalled XFER cycles; any completed beat restarts it.
  assign abort = in_xfer && !bus_ready && (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign err   = err_q;

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= (!in_xfer || bus_ready) ? '0 : to_q + 1'b1;
      err_q <= abort || (err_q && state != DONE);
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state    <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      wr_q     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          base_q <= req_addr[31:K+2];
          idx_q  <= req_addr[K+1:2];
          wr_q   <= req_wr;
          beat_q <= '0;
          state  <= XFER;
        end
        XFER: if (bus_ready) begin
          // Word index wraps within the line; upper address bits stay fixed.
          idx_q  <= idx_q + 1'b1;
          beat_q <= beat_q + 1'b1;
          if (!wr_q) begin
            rd_data  <= bus_rdata;
            rd_valid <= 1'b1;
          end
          if (beat_q == LAST) state <= DONE;
        end else if (abort) begin
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
